// File: rtl/layer2_dense_mac.sv
// Sequential dense output layer: 10 neurons computed one at a time through a single
// shared multiplier, with weights and biases streamed from an external ROM.
module layer2_dense_mac #(
    parameter int unsigned BITS   = 32,
    parameter int unsigned HIDDEN = 32,
    parameter int unsigned FRAC   = 16,
    localparam int unsigned AddrW = $clog2(10 * (HIDDEN + 1))
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BITS*HIDDEN-1:0]   layer_1,
    output logic [AddrW-1:0]         w_addr,
    input  logic [BITS-1:0]          w_data,
    output logic                     busy,
    output logic                     done,
    output logic [BITS*10-1:0]       layer_2
);

    localparam int unsigned AccW = 2 * BITS + 8;
    localparam int unsigned IdxW = $clog2(HIDDEN + 1);
    localparam int unsigned XW   = $clog2(HIDDEN);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(HIDDEN);
    localparam logic signed [AccW-1:0] MaxV = {{(AccW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [AccW-1:0] MinV = {{(AccW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StStore, StDone} state_e;

    state_e                  state_q;
    logic [3:0]              n_q;
    logic [IdxW-1:0]         i_q;
    logic [IdxW-1:0]         mac_j_q;
    logic                    mac_v_q;
    logic signed [AccW-1:0]  acc_q;
    logic [AddrW-1:0]        addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic [BITS*10-1:0]      layer_2_q;
    logic [BITS-1:0]         x_q   [HIDDEN];
    logic [BITS-1:0]         buf_q [10];

    logic signed [BITS-1:0]   x_sel;
    logic signed [2*BITS-1:0] prod;
    logic signed [AccW-1:0]   addend;
    logic signed [AccW-1:0]   shifted;
    logic [BITS-1:0]          score;

    assign w_addr  = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign layer_2 = layer_2_q;

    // Data on w_data belongs to the index issued in the previous RUN cycle (mac_j_q).
    always_comb begin
        x_sel  = $signed(x_q[mac_j_q[XW-1:0]]);
        prod   = $signed(w_data) * x_sel;
        addend = {{(AccW-2*BITS){prod[2*BITS-1]}}, prod};
        if (mac_j_q == LastIdx) begin
            addend = {{(AccW-BITS){w_data[BITS-1]}}, w_data} <<< FRAC;
        end
    end

    always_comb begin
        shifted = acc_q >>> FRAC;
        score   = shifted[BITS-1:0];
        if (shifted > MaxV) begin
            score = MaxV[BITS-1:0];
        end else if (shifted < MinV) begin
            score = MinV[BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= '0;
            i_q       <= '0;
            mac_j_q   <= '0;
            mac_v_q   <= 1'b0;
            acc_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            layer_2_q <= '0;
            for (int k = 0; k < HIDDEN; k++) x_q[k] <= '0;
            for (int k = 0; k < 10; k++) buf_q[k] <= '0;
        end else begin
            done_q  <= 1'b0;
            mac_v_q <= 1'b0;
            if (mac_v_q) begin
                acc_q <= acc_q + addend;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int k = 0; k < HIDDEN; k++) begin
                            x_q[k] <= layer_1[BITS*(HIDDEN-k)-1 -: BITS];
                        end
                        n_q     <= '0;
                        i_q     <= '0;
                        acc_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    mac_v_q <= 1'b1;
                    mac_j_q <= i_q;
                    if (i_q == LastIdx) begin
                        state_q <= StDrain;
                    end else begin
                        i_q    <= i_q + IdxW'(1);
                        addr_q <= addr_q + AddrW'(1);
                    end
                end
                StDrain: begin
                    state_q <= StStore;
                end
                StStore: begin
                    buf_q[n_q] <= score;
                    acc_q      <= '0;
                    i_q        <= '0;
                    if (n_q == 4'd9) begin
                        // Publish now so layer_2 and done change together in the DONE cycle.
                        for (int k = 0; k < 9; k++) begin
                            layer_2_q[BITS*(10-k)-1 -: BITS] <= buf_q[k];
                        end
                        layer_2_q[BITS-1:0] <= score;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        n_q     <= n_q + 4'd1;
                        addr_q  <= addr_q + AddrW'(1);
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_layer2_dense_mac.sv
// Directed bench for layer2_dense_mac (HIDDEN=4) with a synchronous ROM model.
module tb_layer2_dense_mac;

    localparam int BITS   = 32;
    localparam int HIDDEN = 4;
    localparam int FRAC   = 16;
    localparam int AW     = $clog2(10 * (HIDDEN + 1));

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [BITS*HIDDEN-1:0] layer_1;
    logic [AW-1:0]          w_addr;
    logic [BITS-1:0]        w_data;
    logic                   busy;
    logic                   done;
    logic [BITS*10-1:0]     layer_2;

    logic [31:0] rom [0:49];
    int n_checks = 0;
    int n_errors = 0;

    layer2_dense_mac #(.BITS(BITS), .HIDDEN(HIDDEN), .FRAC(FRAC)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .layer_1 (layer_1),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .busy    (busy),
        .done    (done),
        .layer_2 (layer_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) w_data <= rom[w_addr];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slot(input logic [BITS*10-1:0] l2, input int n);
        return l2[BITS*(10-n)-1 -: BITS];
    endfunction

    // Downstream argmax over scores 1..9, first maximum wins.
    function automatic int argmax_digit(input logic [BITS*10-1:0] l2);
        int best = 1;
        for (int d = 2; d < 10; d++) begin
            if ($signed(slot(l2, d)) > $signed(slot(l2, best))) best = d;
        end
        return best;
    endfunction

    task automatic rom_clear;
        for (int k = 0; k < 50; k++) rom[k] = '0;
    endtask

    task automatic set_w(input int n, input int i, input logic [31:0] v);
        rom[n*(HIDDEN+1)+i] = v;
    endtask

    task automatic start_pulse;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the accepting edge to the edge that samples done high.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("done_seen", done, 1'b1);
    endtask

    int cyc;
    int bad;
    int extra;
    logic [BITS*10-1:0] prev;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        layer_1 = '0;
        rom_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_layer_2", layer_2, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_w_addr", w_addr, '0);

        // Biases only: slot n = n*1.0
        for (int n = 0; n < 10; n++) set_w(n, HIDDEN, 32'(n) << 16);
        layer_1 = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        start_pulse();
        check_eq("t1_busy", busy, 1'b1);
        wait_done(cyc);
        check_eq("t1_latency", cyc, 71);
        for (int n = 0; n < 10; n++) check_eq($sformatf("t1_slot%0d", n), slot(layer_2, n), 32'(n) << 16);
        @(negedge clk);
        check_eq("t1_done_pulse", done, 1'b0);
        check_eq("t1_busy_after", busy, 1'b0);

        // Single active neuron 3 -> 2.5, argmax digit 3
        rom_clear();
        set_w(3, 0, 32'h0001_0000);
        set_w(3, 1, 32'h0001_0000);
        set_w(3, 2, 32'h0001_0000);
        set_w(3, 3, 32'h0002_0000);
        set_w(3, 4, 32'hFFFF_8000);
        layer_1 = {32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000};
        start_pulse();
        layer_1 = '1;
        wait_done(cyc);
        check_eq("t2_latency", cyc, 71);
        check_eq("t2_slot3", slot(layer_2, 3), 32'h0002_8000);
        check_eq("t2_slot0", slot(layer_2, 0), 32'h0);
        check_eq("t2_slot9", slot(layer_2, 9), 32'h0);
        check_eq("t2_digit", argmax_digit(layer_2), 3);

        // Restarts at cycle 20 and in the DONE cycle must be ignored
        prev = '0;
        prev[BITS*7-1 -: BITS] = 32'h0002_8000;
        rom_clear();
        for (int n = 0; n < 10; n++) set_w(n, HIDDEN, 32'(n) << 16);
        start_pulse();
        cyc = 1;
        bad = 0;
        while (!done && cyc < 300) begin
            if (layer_2 !== prev) bad++;
            start = (cyc == 20);
            @(negedge clk);
            cyc++;
        end
        check_eq("t5_latency", cyc, 71);
        check_eq("t5_hold_prev", bad, 0);
        check_eq("t5_slot7", slot(layer_2, 7), 32'h0007_0000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_busy_after", busy, 1'b0);
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) extra++;
        end
        check_eq("t5_extra_done", extra, 0);

        // Saturation both ways
        rom_clear();
        for (int i = 0; i < HIDDEN; i++) begin
            set_w(0, i, 32'h7FFF_0000);
            set_w(1, i, 32'h8001_0000);
        end
        layer_1 = {4{32'h7FFF_0000}};
        start_pulse();
        wait_done(cyc);
        check_eq("t3_sat_pos", slot(layer_2, 0), 32'h7FFF_FFFF);
        check_eq("t3_sat_neg", slot(layer_2, 1), 32'h8000_0000);
        check_eq("t3_slot2", slot(layer_2, 2), 32'h0);

        // Arithmetic shift floors toward -inf
        rom_clear();
        set_w(0, 0, 32'h0000_0001);
        set_w(1, 1, 32'hFFFF_FFFF);
        set_w(2, 1, 32'h0000_0001);
        layer_1 = {32'hFFFF_0000, 32'h0000_0001, 32'h0, 32'h0};
        start_pulse();
        wait_done(cyc);
        check_eq("t4_neg_one", slot(layer_2, 0), 32'hFFFF_FFFF);
        check_eq("t4_floor", slot(layer_2, 1), 32'hFFFF_FFFF);
        check_eq("t4_pos_frac", slot(layer_2, 2), 32'h0);

        // Reset mid-run aborts and clears, then a fresh run completes
        start_pulse();
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_layer_2_clr", layer_2, '0);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_done", done, 1'b0);
        start_pulse();
        wait_done(cyc);
        check_eq("t6_latency", cyc, 71);
        check_eq("t6_floor", slot(layer_2, 1), 32'hFFFF_FFFF);
        check_eq("t6_slot0", slot(layer_2, 0), 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
